// File: rtl/traffic_injector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_injector_pkg
// Purpose  : Shared definitions for the traffic injector and its router.
//            It holds the op encodings, the Data* field positions, the Init
//            packet-count field, the Buffer*/Flit* field positions and a
//            saturating counter helper.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_injector_pkg;

  // Command encoding. Any unlisted value decodes as a NOP.
  localparam int OP_SIZE = 3;
  typedef enum logic [OP_SIZE-1:0] {
    OP_NOP     = 3'd0,
    OP_INIT    = 3'd5,
    OP_FILL    = 3'd6,
    OP_DEQUEUE = 3'd7
  } op_e;

  // Command payload layout
  localparam int DATA_BIT_SIZE  = 32;
  localparam int INIT_CNT_MSB   = 31;   // Init: total packet count
  localparam int INIT_CNT_LSB   = 22;
  localparam int CNT_W          = INIT_CNT_MSB - INIT_CNT_LSB + 1;
  localparam int DATA_NFLIT_LSB = 0;    // Fill: DataNumFlit (NFLIT_W bits)
  localparam int DATA_VC_LSB    = 8;    // Fill: DataVc      (VC_W bits)
  localparam int DATA_DST_LSB   = 16;   // Fill: DataDst     (DST_W bits)

  // Buffer layout, LSB first: FlitDst, FlitTail, FlitHead, BufferVc, BufferFull
  localparam int FLIT_DST_LSB = 0;

  function automatic int flit_tail_bit(input int dst_w);
    return dst_w;
  endfunction

  function automatic int flit_head_bit(input int dst_w);
    return dst_w + 1;
  endfunction

  function automatic int buffer_vc_lsb(input int dst_w);
    return dst_w + 2;
  endfunction

  function automatic int buffer_full_bit(input int dst_w, input int vc_w);
    return dst_w + vc_w + 2;
  endfunction

  function automatic int buffer_bit_size(input int dst_w, input int vc_w);
    return dst_w + vc_w + 3;
  endfunction

  // The counters stick at all-ones rather than wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage : traffic_injector_pkg
`default_nettype wire

// File: rtl/inj_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inj_desc_fifo
// Purpose  : An in-order packet-descriptor FIFO. Pointers carry one extra wrap
//            bit, which separates the full state from the empty state.
// Ports    : clk, rst_n     - clock, async active-low reset
//            clear          - synchronous flush (Init)
//            push/push_data - write one descriptor (ignored when full)
//            pop            - drop head descriptor (ignored when empty)
//            full, empty    - occupancy flags
//            empty_nxt      - value that empty takes after this edge
//            head           - descriptor at the read pointer
// Revision : 1.0 - initial release
// ============================================================================
module inj_desc_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt,
  output logic [WIDTH-1:0] head
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_addr_w:0] r_wr_ptr;
  logic [c_addr_w:0] r_rd_ptr;
  logic [c_addr_w:0] w_wr_nxt;
  logic [c_addr_w:0] w_rd_nxt;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  // Same slot index with different wrap bits: the writer is a full lap ahead
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_comb begin
    w_wr_nxt = r_wr_ptr;
    w_rd_nxt = r_rd_ptr;
    if (clear) begin
      w_wr_nxt = '0;
      w_rd_nxt = '0;
    end else begin
      if (w_do_push) w_wr_nxt = r_wr_ptr + c_ptr_one;
      if (w_do_pop)  w_rd_nxt = r_rd_ptr + c_ptr_one;
    end
  end

  assign empty_nxt = (w_wr_nxt == w_rd_nxt);
  assign head      = r_mem[r_rd_ptr[c_addr_w-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
    end
  end

  // Storage is not reset. The flags gate every read, so a stale entry is
  // never visible.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr[c_addr_w-1:0]] <= push_data;
  end

endmodule : inj_desc_fifo
`default_nettype wire

// File: rtl/traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : traffic_injector
// Purpose  : A NoC traffic injector. The host loads packet descriptors with
//            Fill. Each Dequeue then steps the injector through the flits of
//            the head packet.
// Ports    : clk, rst_n - clock, async active-low reset
//            op, data   - command (NOP/Init/Fill/Dequeue) and its payload
//            done       - every expected packet has been loaded and injected
//            buffer     - current flit {BufferFull, BufferVc, FlitHead,
//                         FlitTail, FlitDst}
//            overflow   - sticky: a Fill was dropped because the FIFO was full
//            stall_cnt  - cycles with a full buffer and no Dequeue (only when
//                         TRAFFIC_INJECTOR_STATS_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_injector
  import traffic_injector_pkg::*;
#(
  parameter int PKT_DEPTH = 16,
  parameter int DST_W     = 8,
  parameter int VC_W      = 2,
  parameter int NFLIT_W   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [OP_SIZE-1:0]                        op,
  input  logic [DATA_BIT_SIZE-1:0]                  data,
  output logic                                      done,
  output logic [buffer_bit_size(DST_W, VC_W)-1:0]   buffer,
  output logic                                      overflow
`ifdef TRAFFIC_INJECTOR_STATS_EN
  ,
  output logic [31:0]                               stall_cnt
`endif
);

  localparam int c_desc_w   = DST_W + VC_W + NFLIT_W;
  localparam int c_full_bit = buffer_full_bit(DST_W, VC_W);
  localparam int c_vc_lsb   = buffer_vc_lsb(DST_W);
  localparam int c_head_bit = flit_head_bit(DST_W);
  localparam int c_tail_bit = flit_tail_bit(DST_W);
  localparam logic [NFLIT_W-1:0] c_nflit_one = NFLIT_W'(1);

  // Command decode
  logic w_is_init, w_is_fill, w_is_deq;
  assign w_is_init = (op == OP_INIT);
  assign w_is_fill = (op == OP_FILL);
  assign w_is_deq  = (op == OP_DEQUEUE);

  // Not every data bit belongs to a field. Fold them together so that the
  // unused bits are intentionally sunk.
  logic w_unused_data;
  assign w_unused_data = ^data;

  // Descriptor FIFO
  logic [c_desc_w-1:0] w_fill_desc, w_head;
  logic                w_full, w_empty, w_empty_nxt, w_push, w_pop;
  logic [DST_W-1:0]    w_head_dst;
  logic [VC_W-1:0]     w_head_vc;
  logic [NFLIT_W-1:0]  w_head_nflit, w_last_idx;
  logic                w_tail, w_deq_ok;

  assign w_fill_desc = {data[DATA_DST_LSB +: DST_W],
                        data[DATA_VC_LSB +: VC_W],
                        data[DATA_NFLIT_LSB +: NFLIT_W]};
  assign {w_head_dst, w_head_vc, w_head_nflit} = w_head;

  inj_desc_fifo #(
    .DEPTH (PKT_DEPTH),
    .WIDTH (c_desc_w)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_is_init),
    .push      (w_push),
    .push_data (w_fill_desc),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .empty_nxt (w_empty_nxt),
    .head      (w_head)
  );

  // Registered state
  logic [NFLIT_W-1:0] r_flit_cnt;
  logic [CNT_W-1:0]   r_sent_cnt, r_loaded_cnt, r_expected_cnt;
  logic               r_init_seen, r_overflow, r_done;

  // A descriptor with nflit==0 is sent as a single flit
  assign w_last_idx = (w_head_nflit == '0) ? '0 : w_head_nflit - c_nflit_one;
  assign w_tail     = (r_flit_cnt == w_last_idx);
  assign w_deq_ok   = w_is_deq && !w_empty;
  assign w_pop      = w_deq_ok && w_tail;
  assign w_push     = w_is_fill && !w_full;

  // Next-state values. done is registered from these so that it reflects the
  // state that this edge produces.
  logic [NFLIT_W-1:0] w_flit_nxt;
  logic [CNT_W-1:0]   w_sent_nxt, w_loaded_nxt, w_expected_nxt;
  logic               w_init_seen_nxt, w_overflow_nxt, w_done_nxt;

  always_comb begin
    w_flit_nxt      = r_flit_cnt;
    w_sent_nxt      = r_sent_cnt;
    w_loaded_nxt    = r_loaded_cnt;
    w_expected_nxt  = r_expected_cnt;
    w_init_seen_nxt = r_init_seen;
    w_overflow_nxt  = r_overflow;
    if (w_is_init) begin
      // Init discards any partially sent packet
      w_flit_nxt      = '0;
      w_sent_nxt      = '0;
      w_loaded_nxt    = '0;
      w_expected_nxt  = data[INIT_CNT_MSB:INIT_CNT_LSB];
      w_init_seen_nxt = 1'b1;
      w_overflow_nxt  = 1'b0;
    end else begin
      if (w_pop) begin
        w_flit_nxt = '0;
        w_sent_nxt = sat_inc(r_sent_cnt);
      end else if (w_deq_ok) begin
        w_flit_nxt = r_flit_cnt + c_nflit_one;
      end
      if (w_push)               w_loaded_nxt   = sat_inc(r_loaded_cnt);
      if (w_is_fill && w_full)  w_overflow_nxt = 1'b1;
    end
    w_done_nxt = (w_sent_nxt == w_expected_nxt) && w_empty_nxt && w_init_seen_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_cnt     <= '0;
      r_sent_cnt     <= '0;
      r_loaded_cnt   <= '0;
      r_expected_cnt <= '0;
      r_init_seen    <= 1'b0;
      r_overflow     <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_flit_cnt     <= w_flit_nxt;
      r_sent_cnt     <= w_sent_nxt;
      r_loaded_cnt   <= w_loaded_nxt;
      r_expected_cnt <= w_expected_nxt;
      r_init_seen    <= w_init_seen_nxt;
      r_overflow     <= w_overflow_nxt;
      r_done         <= w_done_nxt;
    end
  end

  assign done     = r_done;
  assign overflow = r_overflow;

  // buffer is decoded only from flops (FIFO pointers, storage, flit_cnt), so
  // op and data have no combinational path to it. An empty FIFO gives an
  // all-zero buffer, and this includes the time while reset is asserted.
  always_comb begin
    buffer = '0;
    if (!w_empty) begin
      buffer[c_full_bit]                    = 1'b1;
      buffer[c_vc_lsb +: VC_W]              = w_head_vc;
      buffer[c_head_bit]                    = (r_flit_cnt == '0);
      buffer[c_tail_bit]                    = w_tail;
      buffer[FLIT_DST_LSB +: DST_W]         = w_head_dst;
    end
  end

`ifdef TRAFFIC_INJECTOR_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_is_init) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !w_is_deq && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule : traffic_injector
`default_nettype wire

// File: tb/tb_traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_injector
// Purpose  : Directed self-checking bench for traffic_injector. Buffer layout
//            (default widths): [12] full, [11:10] vc, [9] head, [8] tail,
//            [7:0] dst. Fill data: dst<<16 | vc<<8 | nflit. Init data: n<<22.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_injector;

  localparam int PKT_DEPTH = 16;
  localparam logic [2:0] NOP = 3'd0, INIT = 3'd5, FILL = 3'd6, DEQ = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op = NOP;
  logic [31:0] data = '0;
  logic        done;
  logic [12:0] buffer;
  logic        overflow;
`ifdef TRAFFIC_INJECTOR_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  traffic_injector #(
    .PKT_DEPTH (PKT_DEPTH),
    .DST_W     (8),
    .VC_W      (2),
    .NFLIT_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .data     (data),
    .done     (done),
    .buffer   (buffer),
    .overflow (overflow)
`ifdef TRAFFIC_INJECTOR_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [12:0] fb(input logic [1:0] vc, input logic hd,
                                     input logic tl, input logic [7:0] dst);
    return {1'b1, vc, hd, tl, dst};
  endfunction

  function automatic logic [31:0] fill_d(input int dst, input int vc, input int nf);
    return 32'((dst << 16) | (vc << 8) | nf);
  endfunction

  function automatic logic [31:0] init_d(input int n);
    return 32'(n << 22);
  endfunction

  // Drive one command for one edge. Outputs are sampled 1 time unit after it.
  task automatic cyc(input logic [2:0] o, input logic [31:0] d);
    op = o; data = d;
    @(posedge clk); #1;
    op = NOP; data = '0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (buffer !== 13'h0) $display("FAIL reset_buffer got=%h exp=%h", buffer, 13'h0); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_packet();
    cyc(INIT, init_d(1));
    n_checks++; if (done !== 1'b0) $display("FAIL sp_done_init got=%b exp=0", done); else n_pass++;
    cyc(FILL, fill_d(3, 1, 3));
    n_checks++; if (buffer !== fb(2'd1, 1, 0, 8'd3)) $display("FAIL sp_flit0 got=%h exp=%h", buffer, fb(2'd1, 1, 0, 8'd3)); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (buffer !== fb(2'd1, 0, 0, 8'd3)) $display("FAIL sp_flit1 got=%h exp=%h", buffer, fb(2'd1, 0, 0, 8'd3)); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (buffer !== fb(2'd1, 0, 1, 8'd3)) $display("FAIL sp_flit2 got=%h exp=%h", buffer, fb(2'd1, 0, 1, 8'd3)); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL sp_done_early got=%b exp=0", done); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (buffer !== 13'h0) $display("FAIL sp_empty got=%h exp=0", buffer); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL sp_done got=%b exp=1", done); else n_pass++;
  endtask

  task automatic test_zero_flit();
    cyc(INIT, init_d(2));
    cyc(FILL, fill_d(5, 2, 0));
    cyc(FILL, fill_d(6, 3, 1));
    n_checks++; if (buffer !== fb(2'd2, 1, 1, 8'd5)) $display("FAIL zf_pkt0 got=%h exp=%h", buffer, fb(2'd2, 1, 1, 8'd5)); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (buffer !== fb(2'd3, 1, 1, 8'd6)) $display("FAIL zf_pkt1 got=%h exp=%h", buffer, fb(2'd3, 1, 1, 8'd6)); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL zf_done_early got=%b exp=0", done); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (buffer !== 13'h0) $display("FAIL zf_empty got=%h exp=0", buffer); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL zf_done got=%b exp=1", done); else n_pass++;
  endtask

  task automatic test_overflow();
    cyc(INIT, init_d(PKT_DEPTH));
    for (int i = 0; i < PKT_DEPTH; i++) cyc(FILL, fill_d(8'h10 + i, i % 4, 1));
    n_checks++; if (overflow !== 1'b0) $display("FAIL of_not_yet got=%b exp=0", overflow); else n_pass++;
    cyc(FILL, fill_d(8'hEE, 0, 1));
    n_checks++; if (overflow !== 1'b1) $display("FAIL of_flag got=%b exp=1", overflow); else n_pass++;
    n_checks++; if (dut.r_loaded_cnt !== 10'(PKT_DEPTH)) $display("FAIL of_loaded got=%0d exp=%0d", dut.r_loaded_cnt, PKT_DEPTH); else n_pass++;
    for (int i = 0; i < PKT_DEPTH; i++) begin
      n_checks++;
      if (buffer !== fb(2'(i % 4), 1, 1, 8'(8'h10 + i)))
        $display("FAIL of_stream_%0d got=%h exp=%h", i, buffer, fb(2'(i % 4), 1, 1, 8'(8'h10 + i)));
      else n_pass++;
      cyc(DEQ, '0);
    end
    n_checks++; if (buffer !== 13'h0) $display("FAIL of_dropped_absent got=%h exp=0", buffer); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL of_done got=%b exp=1", done); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL of_sticky got=%b exp=1", overflow); else n_pass++;
  endtask

  task automatic test_empty_dequeue();
    cyc(INIT, init_d(0));
    n_checks++; if (overflow !== 1'b0) $display("FAIL ed_of_cleared got=%b exp=0", overflow); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (buffer !== 13'h0) $display("FAIL ed_buffer got=%h exp=0", buffer); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL ed_done got=%b exp=1", done); else n_pass++;
    n_checks++; if (dut.r_flit_cnt !== 4'd0) $display("FAIL ed_flit_cnt got=%0d exp=0", dut.r_flit_cnt); else n_pass++;
  endtask

  task automatic test_init_midpacket();
    cyc(FILL, fill_d(7, 2, 4));
    n_checks++; if (buffer !== fb(2'd2, 1, 0, 8'd7)) $display("FAIL mp_flit0 got=%h exp=%h", buffer, fb(2'd2, 1, 0, 8'd7)); else n_pass++;
    cyc(DEQ, '0);
    cyc(DEQ, '0);
    n_checks++; if (dut.r_flit_cnt !== 4'd2) $display("FAIL mp_flit_cnt2 got=%0d exp=2", dut.r_flit_cnt); else n_pass++;
    n_checks++; if (buffer !== fb(2'd2, 0, 0, 8'd7)) $display("FAIL mp_flit2 got=%h exp=%h", buffer, fb(2'd2, 0, 0, 8'd7)); else n_pass++;
    cyc(INIT, init_d(5));
    n_checks++; if (buffer !== 13'h0) $display("FAIL mp_init_buffer got=%h exp=0", buffer); else n_pass++;
    n_checks++; if (dut.r_flit_cnt !== 4'd0) $display("FAIL mp_init_flit_cnt got=%0d exp=0", dut.r_flit_cnt); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL mp_init_done got=%b exp=0", done); else n_pass++;
    cyc(FILL, fill_d(9, 1, 2));
    n_checks++; if (buffer !== fb(2'd1, 1, 0, 8'd9)) $display("FAIL mp_refill got=%h exp=%h", buffer, fb(2'd1, 1, 0, 8'd9)); else n_pass++;
    // Assert reset midway between edges and look before the next edge arrives
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (buffer !== 13'h0) $display("FAIL mp_async_buffer got=%h exp=0", buffer); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL mp_async_done got=%b exp=0", done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // The first edge after release must already accept commands
    cyc(INIT, init_d(1));
    cyc(FILL, fill_d(4, 3, 1));
    n_checks++; if (buffer !== fb(2'd3, 1, 1, 8'd4)) $display("FAIL mp_after_reset got=%h exp=%h", buffer, fb(2'd3, 1, 1, 8'd4)); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (done !== 1'b1) $display("FAIL mp_after_reset_done got=%b exp=1", done); else n_pass++;
  endtask

`ifdef TRAFFIC_INJECTOR_STATS_EN
  task automatic test_stats();
    cyc(INIT, init_d(1));
    cyc(FILL, fill_d(4, 1, 2));
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL st_start got=%0d exp=0", stall_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) cyc(NOP, '0);
    n_checks++; if (stall_cnt !== 32'd5) $display("FAIL st_five got=%0d exp=5", stall_cnt); else n_pass++;
    cyc(DEQ, '0);
    n_checks++; if (stall_cnt !== 32'd5) $display("FAIL st_deq_hold got=%0d exp=5", stall_cnt); else n_pass++;
    cyc(INIT, init_d(0));
    n_checks++; if (stall_cnt !== 32'd0) $display("FAIL st_init_clear got=%0d exp=0", stall_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_zero_flit();
    test_overflow();
    test_empty_dequeue();
    test_init_midpacket();
`ifdef TRAFFIC_INJECTOR_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_traffic_injector
`default_nettype wire
